// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops land in the output register at accept. Divides go
// through an iterative radix-2 restoring divider followed by a sign-fix cycle.
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int ENABLE_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      alu_flags
);

  localparam int SW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam logic [SW-1:0]   CNT_INIT = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [SW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            sel_rem;
  logic            lt_q;
  logic            ltu_q;

  logic            accept;
  logic            lt;
  logic            ltu;
  logic [SW-1:0]   sh;
  logic [XLEN-1:0] imm_res;
  logic            go_div;
  logic            is_rem;
  logic            is_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt;
  logic            qbit;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign lt       = $signed(op1) < $signed(op2);
  assign ltu      = op1 < op2;
  assign sh       = op2[SW-1:0];
  assign is_rem   = alu_op[1];
  assign is_sgn   = ~alu_op[0];
  assign a_neg    = is_sgn && op1[XLEN-1];
  assign b_neg    = is_sgn && op2[XLEN-1];
  assign mag1     = a_neg ? -op1 : op1;
  assign mag2     = b_neg ? -op2 : op2;

  // Single-cycle result, divider fast paths, and the "needs the divider" decision
  always_comb begin
    imm_res = '0;
    go_div  = 1'b0;
    case (alu_op)
      5'd0:  imm_res = op1 + op2;
      5'd1:  imm_res = op1 - op2;
      5'd2:  imm_res = op1 & op2;
      5'd3:  imm_res = op1 | op2;
      5'd4:  imm_res = op1 ^ op2;
      5'd5:  imm_res = op1 << sh;
      5'd6:  imm_res = op1 >> sh;
      5'd7:  imm_res = $signed(op1) >>> sh;
      5'd8:  imm_res = {{(XLEN-1){1'b0}}, lt};
      5'd9:  imm_res = {{(XLEN-1){1'b0}}, ltu};
      5'd10: imm_res = lt  ? op1 : op2;
      5'd11: imm_res = lt  ? op2 : op1;
      5'd12: imm_res = ltu ? op1 : op2;
      5'd13: imm_res = ltu ? op2 : op1;
      // A shift by XLEN yields zero, which covers the sh==0 rotate case
      5'd14: imm_res = (op1 << sh) | (op1 >> (XLEN - sh));
      5'd15: imm_res = (op1 >> sh) | (op1 << (XLEN - sh));
      5'd16, 5'd17, 5'd18, 5'd19: begin
        if (ENABLE_DIV != 0) begin
          if (op2 == '0)
            imm_res = is_rem ? op1 : '1;
          else if (is_sgn && (op1 == MIN_NEG) && (op2 == '1))
            imm_res = is_rem ? '0 : op1;
          else
            go_div = 1'b1;
        end
      end
      default: imm_res = '0;
    endcase
  end

  // One restoring shift-subtract step and the final sign correction
  always_comb begin
    trial   = {rem, quo[XLEN-1]} - {1'b0, dvsr};
    qbit    = ~trial[XLEN];
    rem_nxt = qbit ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
    fin     = sel_rem ? r_fix : q_fix;
  end

  // Control FSM, divider datapath and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      alu_flags <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sel_rem   <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_div) begin
              quo       <= mag1;
              rem       <= '0;
              dvsr      <= mag2;
              cnt       <= CNT_INIT;
              neg_q     <= a_neg ^ b_neg;
              neg_r     <= a_neg;
              sel_rem   <= is_rem;
              lt_q      <= lt;
              ltu_q     <= ltu;
              out_valid <= 1'b0;
              state     <= DIV;
            end else begin
              result    <= imm_res;
              alu_flags <= {lt, ltu, imm_res == '0};
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[XLEN-2:0], qbit};
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          result    <= fin;
          alu_flags <= {lt_q, ltu_q, fin == '0};
          out_valid <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an
// arithmetic reference model; includes an XLEN=64 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [4:0]  alu_op;
  logic [2:0]  alu_flags;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] op1_64, op2_64, result64;
  logic [4:0]  alu_op64;
  logic [2:0]  flags64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32), .ENABLE_DIV(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .alu_flags(alu_flags)
  );

  alu_seq #(.XLEN(64), .ENABLE_DIV(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .op1(op1_64), .op2(op2_64), .alu_op(alu_op64), .out_valid(out_valid64),
    .out_ready(out_ready64), .result(result64), .alu_flags(flags64)
  );

  // Reference model: RV32 semantics written directly in arithmetic
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, b);
    int s;
    logic sl, ul;
    s  = int'(b[4:0]);
    sl = $signed(a) < $signed(b);
    ul = a < b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << s;
      6:  return a >> s;
      7:  return $signed(a) >>> s;
      8:  return {31'd0, sl};
      9:  return {31'd0, ul};
      10: return sl ? a : b;
      11: return sl ? b : a;
      12: return ul ? a : b;
      13: return ul ? b : a;
      14: return (a << s) | (a >> (32 - s));
      15: return (a >> s) | (a << (32 - s));
      16, 18: begin
        if (b == 0) return (op == 16) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 16) ? a : 32'd0;
        if (op == 16) return $signed(a) / $signed(b);
        return $signed(a) % $signed(b);
      end
      17: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      19: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [4:0] op, input logic [31:0] a, b);
    return {$signed(a) < $signed(b), a < b, ref_res(op, a, b) == 32'd0};
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, b);
    if (op < 16 || op > 19 || b == 0) return 1;
    if ((op == 16 || op == 18) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op, optionally keep garbage on in_valid while busy, and time the result
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, b, input bit hold,
                       output logic [31:0] res, output logic [2:0] flg,
                       output int lat, output bit busy_rdy);
    int n;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; op1 = a; op2 = b; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout op=%0d in_ready stuck at %b, required 1", op, in_ready);
    end
    @(posedge clk); #1;
    if (hold) begin
      alu_op = 5'($urandom); op1 = $urandom; op2 = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0; busy_rdy = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (!out_valid && in_ready) busy_rdy = 1'b1;
    end while (!out_valid && lat < 200);
    res = result; flg = alu_flags;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; alu_op = '0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
    op1_64 = '0; op2_64 = '0; alu_op64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (alu_flags !== 3'd0) begin errors++; $display("FAIL reset_flags got %b want 000", alu_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [4:0]  t_op  [13] = '{5'd0, 5'd7, 5'd15, 5'd12, 5'd11, 5'd16, 5'd18, 5'd17, 5'd19,
                                5'd17, 5'd18, 5'd16, 5'd18};
    logic [31:0] t_a   [13] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'd5, 32'd5, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b   [13] = '{32'h1, 32'd4, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [13] = '{32'h0, 32'hF800_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int          t_lat [13] = '{1, 1, 1, 1, 1, 34, 34, 34, 34, 1, 1, 1, 1};
    logic [31:0] r; logic [2:0] f; int lat; bit br;
    for (int i = 0; i < 13; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, r, f, lat, br);
      checks++; if (r !== t_exp[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, r, t_exp[i]); end
      checks++; if (lat != t_lat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t_lat[i]); end
      checks++; if (f !== ref_flags(t_op[i], t_a[i], t_b[i])) begin errors++;
        $display("FAIL dir%0d_flags got %b want %b", i, f, ref_flags(t_op[i], t_a[i], t_b[i])); end
      checks++; if (br !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_in_ready got 1 want 0", i); end
    end
  endtask

  function automatic logic [31:0] pick(input bit is_b);
    case ($urandom_range(0, 3))
      0: return is_b ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 20));
      1: return is_b ? 32'hFFFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b, r; logic [4:0] op; logic [2:0] f; int lat; bit br;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 19)) : 5'($urandom_range(0, 31));
      a = pick(1'b0); b = pick(1'b1);
      do_op(op, a, b, bit'($urandom_range(0, 1)), r, f, lat, br);
      checks++; if (r !== ref_res(op, a, b)) begin errors++;
        $display("FAIL rnd_result op=%0d a=%h b=%h got %h want %h", op, a, b, r, ref_res(op, a, b)); end
      checks++; if (f !== ref_flags(op, a, b)) begin errors++;
        $display("FAIL rnd_flags op=%0d a=%h b=%h got %b want %b", op, a, b, f, ref_flags(op, a, b)); end
      checks++; if (lat != ref_lat(op, a, b)) begin errors++;
        $display("FAIL rnd_latency op=%0d got %0d want %0d", op, lat, ref_lat(op, a, b)); end
      checks++; if (br !== 1'b0) begin errors++; $display("FAIL rnd_busy_in_ready op=%0d got 1 want 0", op); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa [5], qb [5];
    logic [4:0]  qo [5];
    logic [31:0] a0, b0;
    a0 = $urandom; b0 = $urandom;
    for (int i = 0; i < 5; i++) begin
      qo[i] = 5'($urandom_range(0, 15)); qa[i] = $urandom; qb[i] = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd0; op1 = a0; op2 = b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    alu_op = qo[0]; op1 = qa[0]; op2 = qb[0];
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || result !== ref_res(5'd0, a0, b0)) begin errors++;
        $display("FAIL bp_hold%0d valid=%b result=%h want 1/%h", c, out_valid, result, ref_res(5'd0, a0, b0)); end
      checks++; if (alu_flags !== ref_flags(5'd0, a0, b0)) begin errors++;
        $display("FAIL bp_flags%0d got %b want %b", c, alu_flags, ref_flags(5'd0, a0, b0)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== ref_res(qo[i], qa[i], qb[i])) begin errors++;
        $display("FAIL b2b%0d valid=%b result=%h want 1/%h", i, out_valid, result, ref_res(qo[i], qa[i], qb[i])); end
      if (i < 4) begin
        alu_op = qo[i+1]; op1 = qa[i+1]; op2 = qb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  // Start a general divide and stop it after 10 iterations with flush or rst
  task automatic test_interrupt(input bit use_rst);
    logic [31:0] r; logic [2:0] f; int lat; bit br; bit seen;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd17; op1 = $urandom; op2 = 32'($urandom_range(1, 1000)); out_ready = 1'b1;
    @(posedge clk); #1;
    alu_op = 5'd0; op1 = 32'd9; op2 = 32'd9;
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL int%0d_in_ready got %b want 1", use_rst, in_ready); end
    if (use_rst) begin
      checks++; if (result !== 32'd0 || alu_flags !== 3'd0) begin errors++;
        $display("FAIL rst_outputs result=%h flags=%b want 0/000", result, alu_flags); end
    end
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL int%0d_out_valid got 1 want 0", use_rst); end
    do_op(5'd0, 32'd3, 32'd4, 1'b0, r, f, lat, br);
    checks++; if (r !== 32'd7 || lat != 1) begin errors++;
      $display("FAIL int%0d_add result=%h lat=%0d want 7/1", use_rst, r, lat); end
  endtask

  task automatic run64(input logic [4:0] op, input logic [63:0] a, b,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    in_valid64 = 1'b1; alu_op64 = op; op1_64 = a; op2_64 = b; out_ready64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid64 && lat < 200);
    res = result64;
  endtask

  task automatic test_xlen64();
    logic [63:0] r; int lat;
    run64(5'd17, 64'd1 << 40, 64'd3, r, lat);
    checks++; if (r !== 64'd366503875925) begin errors++; $display("FAIL x64_divu got %0d want 366503875925", r); end
    checks++; if (lat != 66) begin errors++; $display("FAIL x64_divu_latency got %0d want 66", lat); end
    run64(5'd14, 64'd1, 64'd63, r, lat);
    checks++; if (r !== 64'h8000_0000_0000_0000 || lat != 1) begin errors++;
      $display("FAIL x64_rol result=%h lat=%0d want 8000000000000000/1", r, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_xlen64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the execute-stage combinational ALU.
- Keeps the base op set (add/sub/logic/shifts/slt/sltu) and adds min/max, rotates and RV32M-style DIV/DIVU/REM/REMU.
- Division runs on an iterative radix-2 divider.
- Sits in the execute stage between operand forwarding and EX/MEM. Valid/ready on input and output lets a multi-cycle divide stall the pipe.

Parameters:
- XLEN, 32, operand/result width; must be ≥8, power of two.
- ENABLE_DIV, 1, 0 removes the divider; div ops return 0 at latency 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill in-flight op; takes effect next edge
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- op1  in  XLEN  operand 1 / dividend
- op2  in  XLEN  operand 2 / divisor / shift amount
- alu_op  in  5  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- alu_flags  out  3  {lt, ltu, zero}, registered with result

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE; out_valid=0; result=0; alu_flags=0; divider registers=0.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 MIN, 11 MAX (signed); 12 MINU, 13 MAXU
  - 14 ROL, 15 ROR
  - 16 DIV, 17 DIVU, 18 REM, 19 REMU
  - 20–31: result 0, latency 1
- Shifts and rotates use op2[log2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN.
- Flags:
  - lt = signed(op1)<signed(op2); ltu = op1<op2; both captured at accept.
  - zero = (result==0), computed on the final result.
- Handshake:
  - Accept happens when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output: result/flags/out_valid hold stable while out_valid && !out_ready.
  - out_valid drops on the transfer edge unless a new result lands the same edge; back-to-back single-cycle ops then sustain 1/cycle.
- Latency:
  - Single-cycle ops: accept at edge N → out_valid high after edge N+1 (registered).
  - Divider fast paths, latency 1:
    - divisor==0: quotient all-ones, remainder = op1.
    - Signed overflow (op1=−2^(XLEN-1), op2=−1): quotient = op1, remainder 0.
  - General divide: latency XLEN+2 (XLEN iterate cycles + 1 sign-fix cycle + output register); out_valid after edge N+XLEN+2.
- FSM:
  - IDLE: accept. Div op without fast path → DIV; magnitudes loaded; quotient/remainder sign flags latched; counter=XLEN-1.
  - DIV: one restoring shift-subtract per cycle; counter decrements. At counter==0 → FIX.
  - FIX: apply two's-complement negation.
    - Quotient negated if signs differ.
    - Remainder takes the dividend's sign.
    - Select quotient or remainder; load output register; → WAIT.
  - WAIT: out_valid high; on out_ready → IDLE.
  - Single-cycle ops stay in IDLE with the result register loaded directly.
- flush:
  - Forces state=IDLE and out_valid=0 next edge; any busy divide is discarded.
  - flush has priority over an accept in the same cycle, and that input is dropped.
- rst mid-divide: same as flush, plus all registers return to reset values.
- in_ready is 0 throughout DIV, FIX and WAIT; a new in_valid is held off and must not corrupt the divider.

Test Plan:
- Single-cycle ops, out_ready=1:
  - ADD 0xFFFFFFFF+1 → result 0, zero=1, latency 1.
  - SRA 0x80000000>>4 → 0xF8000000.
  - ROR 0x00000001 by 1 → 0x80000000.
  - MINU(5, 0xFFFFFFFF) → 5; MAX(5, 0xFFFFFFFF) → 5.
- Signed divide: DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF, DIVU 100/7 → 14, REMU 100/7 → 2. Each out_valid exactly 34 cycles after accept; in_ready=0 meanwhile.
- Divider corners, each latency 1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result → result/flags stable, in_ready=0. Release → next queued op accepted same cycle; 4 back-to-back ops then deliver 1/cycle.
- Flush and reset interrupt a DIV:
  - flush at iteration 10 → out_valid stays 0; in_ready=1 next cycle; following ADD 3+4 → 7 correct.
  - Repeat with rst → all outputs 0.
- XLEN=64 build: DIVU 2^40/3 → 366503875925; out_valid 66 cycles after accept; ROL 1 by 63 → 0x8000000000000000.
